// File: rtl/calc_operand_queue.sv
// calc_operand_queue: head/tail ring buffer of operands for the calculator ALU.
// Presents the two oldest entries as a concatenated pair, supports push,
// pop, pop-and-push and pair-consume-and-push, with flush and a sticky
// illegal-op error report.
module calc_operand_queue #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned PTR_W  = $clog2(DEPTH),
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                op_valid,
  input  logic [1:0]          opcode,
  input  logic [DATA_W-1:0]   back,
  input  logic                flush,
  input  logic                clr_err,
  output logic [2*DATA_W-1:0] top_conc,
  output logic                top_valid,
  output logic [CNT_W-1:0]    count,
  output logic                empty,
  output logic                full,
  output logic                err,
  output logic [1:0]          err_code
);

  typedef enum logic [1:0] {
    OP_PUSH      = 2'b00,
    OP_POP_PUSH  = 2'b01,
    OP_PAIR_PUSH = 2'b10,
    OP_POP       = 2'b11
  } op_e;

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_TWO  = PTR_W'(2);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;

  logic              is_empty_c;
  logic              is_full_c;
  logic              has_pair_c;
  logic              legal_c;
  logic [PTR_W-1:0]  head_nx_c;
  op_e               op_c;

  // Occupancy-derived status shared by op legality checks and outputs.
  always_comb begin
    is_empty_c = (count_q == CNT_ZERO);
    is_full_c  = (count_q == CNT_FULL);
    has_pair_c = (count_q >= CNT_TWO);
    head_nx_c  = head_q + PTR_ONE;
    op_c       = op_e'(opcode);
  end

  // Legality of the presented opcode against the current occupancy.
  always_comb begin
    legal_c = 1'b0;
    unique case (op_c)
      OP_PUSH:      legal_c = !is_full_c;
      OP_POP_PUSH:  legal_c = !is_empty_c;
      OP_PAIR_PUSH: legal_c = has_pair_c;
      OP_POP:       legal_c = !is_empty_c;
      default:      legal_c = 1'b0;
    endcase
  end

  // Next-state: flush beats ops; an illegal op in the same cycle as clr_err wins.
  always_comb begin
    mem_d      = mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    err_d      = err_q;
    err_code_d = err_code_q;

    if (clr_err) begin
      err_d      = 1'b0;
      err_code_d = 2'b00;
    end

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = CNT_ZERO;
    end else if (op_valid) begin
      if (legal_c) begin
        unique case (op_c)
          OP_PUSH: begin
            mem_d[tail_q] = back;
            tail_d        = tail_q + PTR_ONE;
            count_d       = count_q + CNT_ONE;
          end
          OP_POP_PUSH: begin
            // Head slot is released before the write; when full, tail == head.
            mem_d[tail_q] = back;
            tail_d        = tail_q + PTR_ONE;
            head_d        = head_nx_c;
          end
          OP_PAIR_PUSH: begin
            // Two slots are freed, so the write slot is never a live entry.
            mem_d[tail_q] = back;
            tail_d        = tail_q + PTR_ONE;
            head_d        = head_q + PTR_TWO;
            count_d       = count_q - CNT_ONE;
          end
          OP_POP: begin
            head_d  = head_nx_c;
            count_d = count_q - CNT_ONE;
          end
          default: begin
            head_d = head_q;
          end
        endcase
      end else begin
        err_d = 1'b1;
        if (!err_q || clr_err) begin
          err_code_d = opcode;
        end
      end
    end
  end

  // State register with asynchronous reset clearing storage and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q      <= '{default: '0};
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= CNT_ZERO;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      mem_q      <= mem_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // Outputs decoded from registered state; absent entries read as zero.
  always_comb begin
    top_conc[2*DATA_W-1:DATA_W] = is_empty_c ? '0 : mem_q[head_q];
    top_conc[DATA_W-1:0]        = has_pair_c ? mem_q[head_nx_c] : '0;
    top_valid                   = has_pair_c;
    count                       = count_q;
    empty                       = is_empty_c;
    full                        = is_full_c;
    err                         = err_q;
    err_code                    = err_code_q;
  end

endmodule

// File: tb/tb_calc_operand_queue.sv
// Self-checking bench for calc_operand_queue against a queue-based reference model.
module tb_calc_operand_queue;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic            clk;
  logic            rst;
  logic            op_valid;
  logic [1:0]      opcode;
  logic [DW-1:0]   back;
  logic            flush;
  logic            clr_err;
  logic [2*DW-1:0] top_conc;
  logic            top_valid;
  logic [CW-1:0]   count;
  logic            empty;
  logic            full;
  logic            err;
  logic [1:0]      err_code;

  calc_operand_queue #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .opcode(opcode), .back(back),
    .flush(flush), .clr_err(clr_err), .top_conc(top_conc), .top_valid(top_valid),
    .count(count), .empty(empty), .full(full), .err(err), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: plain FIFO plus error flags.
  logic [DW-1:0] mq[$];
  logic          m_err;
  logic [1:0]    m_code;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [2*DW-1:0] m_top();
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
    hi = (mq.size() >= 1) ? mq[0] : '0;
    lo = (mq.size() >= 2) ? mq[1] : '0;
    return {hi, lo};
  endfunction

  task automatic model_apply(input logic v, input logic [1:0] op, input logic [DW-1:0] b,
                             input logic fl, input logic ce);
    logic was_err;
    logic ok;
    was_err = m_err;
    if (ce) begin
      m_err  = 1'b0;
      m_code = 2'b00;
    end
    if (fl) begin
      mq.delete();
    end else if (v) begin
      ok = 1'b1;
      case (op)
        2'b00: if (mq.size() < DEPTH) mq.push_back(b); else ok = 1'b0;
        2'b01: if (mq.size() > 0) begin void'(mq.pop_front()); mq.push_back(b); end
               else ok = 1'b0;
        2'b10: if (mq.size() >= 2) begin
                 void'(mq.pop_front()); void'(mq.pop_front()); mq.push_back(b);
               end else ok = 1'b0;
        default: if (mq.size() > 0) void'(mq.pop_front()); else ok = 1'b0;
      endcase
      if (!ok) begin
        if (!was_err || ce) m_code = op;
        m_err = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".top_conc"},  32'(top_conc),  32'(m_top()));
    check({tag, ".count"},     32'(count),     32'(mq.size()));
    check({tag, ".top_valid"}, 32'(top_valid), 32'(mq.size() >= 2));
    check({tag, ".empty"},     32'(empty),     32'(mq.size() == 0));
    check({tag, ".full"},      32'(full),      32'(mq.size() == DEPTH));
    check({tag, ".err"},       32'(err),       32'(m_err));
    check({tag, ".err_code"},  32'(err_code),  32'(m_code));
  endtask

  // One clock of stimulus; outputs compared 1ns after the rising edge.
  task automatic step(input string tag, input logic v, input logic [1:0] op,
                      input logic [DW-1:0] b, input logic fl, input logic ce);
    op_valid = v; opcode = op; back = b; flush = fl; clr_err = ce;
    @(posedge clk);
    #1;
    model_apply(v, op, b, fl, ce);
    op_valid = 1'b0; flush = 1'b0; clr_err = 1'b0;
    opcode = 2'($urandom); back = DW'($urandom);
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; opcode = 2'b00; back = '0; flush = 1'b0; clr_err = 1'b0;
    mq.delete(); m_err = 1'b0; m_code = 2'b00;
    #3;
    check("rst.top_conc", 32'(top_conc), 32'h0);
    check("rst.top_valid", 32'(top_valid), 32'h0);
    check("rst.empty", 32'(empty), 32'h1);
    check("rst.full", 32'(full), 32'h0);
    #9 rst = 1'b0;
    @(posedge clk); #1;

    // 1: three pushes
    step("t1.push", 1'b1, 2'b00, 8'h11, 1'b0, 1'b0);
    step("t1.push", 1'b1, 2'b00, 8'h22, 1'b0, 1'b0);
    step("t1.push", 1'b1, 2'b00, 8'h33, 1'b0, 1'b0);
    check("t1.pair", 32'(top_conc), 32'h1122);
    check("t1.cnt", 32'(count), 32'd3);

    // 2: pair consume then pop
    step("t2.pair", 1'b1, 2'b10, 8'h33, 1'b0, 1'b0);
    check("t2.pair_val", 32'(top_conc), 32'h3333);
    step("t2.pop", 1'b1, 2'b11, 8'h00, 1'b0, 1'b0);
    check("t2.pop_val", 32'(top_conc), 32'h3300);
    check("t2.tv", 32'(top_valid), 32'h0);

    // 3: fill, overflow, pop_push when full
    step("t3.flush", 1'b0, 2'b00, 8'h00, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) step("t3.fill", 1'b1, 2'b00, DW'(i), 1'b0, 1'b0);
    check("t3.full", 32'(full), 32'h1);
    step("t3.ovf", 1'b1, 2'b00, 8'h09, 1'b0, 1'b0);
    check("t3.err", 32'(err), 32'h1);
    check("t3.code", 32'(err_code), 32'h0);
    check("t3.cnt", 32'(count), 32'd8);
    step("t3.pp", 1'b1, 2'b01, 8'h09, 1'b0, 1'b0);
    check("t3.pp_val", 32'(top_conc), 32'h0203);
    check("t3.pp_full", 32'(full), 32'h1);

    // 4: mixed push/pop across the wrap point
    step("t4.clr", 1'b0, 2'b00, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      logic [1:0] op;
      if (mq.size() == DEPTH) op = 2'b11;
      else if (mq.size() == 0) op = 2'b00;
      else op = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
      step("t4.wrap", 1'b1, op, DW'($urandom), 1'b0, 1'b0);
    end

    // 5: illegal ops on empty / single entry, then clear
    step("t5.flush", 1'b0, 2'b00, 8'h00, 1'b1, 1'b0);
    step("t5.pop", 1'b1, 2'b11, 8'h00, 1'b0, 1'b0);
    check("t5.err", 32'(err), 32'h1);
    check("t5.code", 32'(err_code), 32'h3);
    step("t5.push", 1'b1, 2'b00, 8'h5a, 1'b0, 1'b0);
    step("t5.pair1", 1'b1, 2'b10, 8'h77, 1'b0, 1'b0);
    check("t5.code_hold", 32'(err_code), 32'h3);
    check("t5.cnt1", 32'(count), 32'd1);
    step("t5.clr", 1'b0, 2'b00, 8'h00, 1'b0, 1'b1);
    check("t5.err_clr", 32'(err), 32'h0);
    step("t5.pop_clr", 1'b1, 2'b11, 8'h00, 1'b1, 1'b1);
    step("t5.illclr", 1'b1, 2'b11, 8'h00, 1'b0, 1'b0);
    step("t5.win", 1'b1, 2'b10, 8'h00, 1'b0, 1'b1);
    check("t5.win_code", 32'(err_code), 32'h2);

    // 6: asynchronous reset with a pending push
    step("t6.flush", 1'b0, 2'b00, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step("t6.fill", 1'b1, 2'b00, DW'(8'hc0 + i), 1'b0, 1'b0);
    check("t6.cnt5", 32'(count), 32'd5);
    op_valid = 1'b1; opcode = 2'b00; back = 8'haa;
    #2 rst = 1'b1;
    #1;
    check("t6.async_cnt", 32'(count), 32'h0);
    check("t6.async_empty", 32'(empty), 32'h1);
    check("t6.async_top", 32'(top_conc), 32'h0);
    check("t6.async_err", 32'(err), 32'h0);
    @(posedge clk); #1;
    check("t6.hold_cnt", 32'(count), 32'h0);
    check("t6.hold_top", 32'(top_conc), 32'h0);
    op_valid = 1'b0;
    #2 rst = 1'b0;
    mq.delete(); m_err = 1'b0; m_code = 2'b00;
    step("t6.push", 1'b1, 2'b00, 8'h55, 1'b0, 1'b0);
    check("t6.single", 32'(top_conc), 32'h5500);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic v, fl, ce;
      v  = ($urandom_range(0, 9) < 8);
      fl = ($urandom_range(0, 39) == 0);
      ce = ($urandom_range(0, 14) == 0);
      step("rnd", v, 2'($urandom), DW'($urandom), fl, ce);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
